// File: rtl/wave_flash_rd.sv
// wave_flash_rd: mode-0 SPI flash reader, NCYC 32-bit reads (two little-endian words each) per ena frame; WAVE_FLASH_RD_FAST_READ_EN selects 0x0B + 8 dummy sclks.
// Latency 64 (72 fast) sclks of 2*DIV clks per read; no backpressure: ena while busy is dropped and flagged on ovr.
module wave_flash_rd #(
  parameter int DIV  = 2,
  parameter int NCYC = 4,
  parameter int GAP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  output logic [1:0]  cyc_num,
  input  logic [23:0] addr,
  output logic [15:0] data,
  output logic        data_stb,
  output logic        busy,
  output logic        ovr,
  output logic        spi_csl,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef WAVE_FLASH_RD_FAST_READ_EN
  localparam logic [7:0] RD_CMD    = 8'h0B;
  localparam bit         USE_DUMMY = 1'b1;
`else
  localparam logic [7:0] RD_CMD    = 8'h03;
  localparam bit         USE_DUMMY = 1'b0;
`endif

  localparam int PH_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [1:0]       CYC_LAST = 2'(NCYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LATCH, ST_CMD, ST_ADR, ST_DUMMY, ST_DATA, ST_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [PH_W-1:0]   ph_cnt;
  logic [4:0]        bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [30:0]       tx_sh;
  logic [14:0]       rx_sh;
  logic              shifting, ph_end, sclk_rise, sclk_fall, gap_done;

  // sclk_rise/sclk_fall mark the clk edge on which spi_sclk is about to toggle.
  always_comb begin
    shifting  = (state == ST_CMD) || (state == ST_ADR) ||
                (state == ST_DUMMY) || (state == ST_DATA);
    ph_end    = shifting && (ph_cnt == PH_LAST);
    sclk_rise = ph_end && !spi_sclk;
    sclk_fall = ph_end && spi_sclk;
    gap_done  = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (ena) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_CMD;
      ST_CMD:   if (sclk_fall && bit_cnt == 5'd7)  state_nxt = ST_ADR;
      ST_ADR:   if (sclk_fall && bit_cnt == 5'd23) state_nxt = USE_DUMMY ? ST_DUMMY : ST_DATA;
      ST_DUMMY: if (sclk_fall && bit_cnt == 5'd7)  state_nxt = ST_DATA;
      ST_DATA:  if (sclk_fall && bit_cnt == 5'd31) state_nxt = ST_GAP;
      ST_GAP:   if (gap_done) state_nxt = (cyc_num == CYC_LAST) ? ST_IDLE : ST_LATCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_num  <= '0;
      data     <= '0;
      data_stb <= 1'b0;
      busy     <= 1'b0;
      ovr      <= 1'b0;
      spi_csl  <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      ph_cnt   <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      data_stb <= 1'b0;
      ovr      <= ena && (state != ST_IDLE);
      ph_cnt   <= (shifting && !ph_end) ? ph_cnt + 1'b1 : '0;
      gap_cnt  <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      if (ph_end)    spi_sclk <= !spi_sclk;
      if (sclk_fall) bit_cnt  <= (state_nxt != state) ? 5'd0 : bit_cnt + 5'd1;

      case (state)
        ST_IDLE: if (ena) begin
          cyc_num <= '0;
          busy    <= 1'b1;
        end
        // cyc_num has been stable for this whole clk, so addr is valid here.
        ST_LATCH: begin
          tx_sh    <= {RD_CMD[6:0], addr};
          spi_mosi <= RD_CMD[7];
          spi_csl  <= 1'b0;
        end
        ST_CMD, ST_ADR: if (sclk_fall) begin
          spi_mosi <= (state_nxt == ST_CMD || state_nxt == ST_ADR) ? tx_sh[30] : 1'b0;
          tx_sh    <= {tx_sh[29:0], 1'b0};
        end
        ST_DATA: begin
          if (sclk_rise) begin
            rx_sh <= {rx_sh[13:0], spi_miso};
            // First byte received is the low byte of each word.
            if (bit_cnt[3:0] == 4'hF) begin
              data     <= {rx_sh[6:0], spi_miso, rx_sh[14:7]};
              data_stb <= 1'b1;
            end
          end
          if (sclk_fall && bit_cnt == 5'd31) spi_csl <= 1'b1;
        end
        ST_GAP: if (gap_done) begin
          if (cyc_num == CYC_LAST) begin
            cyc_num <= '0;
            busy    <= 1'b0;
          end else begin
            cyc_num <= cyc_num + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_flash_rd.sv
// Directed bench for wave_flash_rd with a behavioural mode-0 SPI flash; define WAVE_FLASH_RD_FAST_READ_EN for the fast-read build.
`timescale 1ns/1ps
module tb_wave_flash_rd;
  localparam int DIV  = 2;
  localparam int NCYC = 4;
  localparam int GAP  = 4;
`ifdef WAVE_FLASH_RD_FAST_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int N_HDR = 40;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int N_HDR = 32;
`endif
  localparam int NSCLK     = N_HDR + 32;
  localparam int CS_LEN    = NSCLK * 2 * DIV;
  localparam int FRAME_LEN = NCYC * (1 + CS_LEN + GAP);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ena = 1'b0;
  logic [1:0]  cyc_num;
  logic [23:0] addr;
  logic [15:0] data;
  logic        data_stb, busy, ovr, spi_csl, spi_sclk, spi_mosi;
  logic        spi_miso = 1'b1;
  logic [23:0] addr_tab [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always_comb addr = addr_tab[cyc_num];

  wave_flash_rd #(.DIV(DIV), .NCYC(NCYC), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .ena(ena), .cyc_num(cyc_num), .addr(addr),
    .data(data), .data_stb(data_stb), .busy(busy), .ovr(ovr),
    .spi_csl(spi_csl), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  function automatic logic [7:0] fb(input logic [23:0] a);
    case (a)
      24'h000100: fb = 8'h34;
      24'h000101: fb = 8'h12;
      24'h000102: fb = 8'h78;
      24'h000103: fb = 8'h56;
      default:    fb = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endcase
  endfunction

  // Monitor and flash model; all state lives here.
  int          neg_cnt = 0, stb_cnt = 0, ovr_cnt = 0, txn_cnt = 0, mosi_err = 0;
  int          run_min = 1000, run_max = 0, run = 0;
  int          hdr_cnt = 0, dcnt = 0, rise_cnt = 0, cs_start = 0;
  bit          csl_p = 1'b1, sclk_p = 1'b0, settle = 1'b0;
  logic [31:0] hdr = '0;
  logic [7:0]  fbyte;
  logic        cur_bit = 1'b0;
  logic [15:0] stb_q[$];
  int          stb_t_q[$];
  logic [31:0] hdr_q[$];
  int          cyc_q[$];
  int          cs_len_q[$];
  int          rise_q[$];

  always @(negedge clk) begin
    neg_cnt++;
    if (reset) begin
      csl_p = 1'b1; sclk_p = 1'b0; hdr_cnt = 0; dcnt = 0; rise_cnt = 0; settle = 1'b0;
    end else begin
      if (data_stb) begin stb_cnt++; stb_q.push_back(data); stb_t_q.push_back(neg_cnt); end
      if (ovr) ovr_cnt++;
      if (spi_csl) begin
        if (!csl_p) begin cs_len_q.push_back(neg_cnt - cs_start); rise_q.push_back(rise_cnt); end
        if (spi_mosi) mosi_err++;
        hdr_cnt = 0; dcnt = 0; rise_cnt = 0; settle = 1'b0; spi_miso = 1'b1;
      end else begin
        if (csl_p) begin
          txn_cnt++; cyc_q.push_back(int'(cyc_num)); cs_start = neg_cnt; run = 1;
        end else if (spi_sclk == sclk_p) begin
          run++;
        end else begin
          if (run < run_min) run_min = run;
          if (run > run_max) run_max = run;
          run = 1;
        end
        if (hdr_cnt >= N_HDR && spi_mosi) mosi_err++;
        if (spi_sclk && !sclk_p) begin
          rise_cnt++;
          if (hdr_cnt < 32) begin
            hdr = {hdr[30:0], spi_mosi}; hdr_cnt++;
            if (hdr_cnt == 32) hdr_q.push_back(hdr);
          end else if (hdr_cnt < N_HDR) begin
            if (spi_mosi) mosi_err++;
            hdr_cnt++;
          end else begin
            spi_miso = ~cur_bit;   // garbage while sclk is high
          end
          settle = 1'b0;
        end else if (!spi_sclk && sclk_p && hdr_cnt == N_HDR) begin
          fbyte = fb(hdr[23:0] + 24'(dcnt / 8));
          cur_bit = fbyte[7 - (dcnt % 8)];
          dcnt++; spi_miso = ~cur_bit; settle = 1'b1;
        end else if (settle) begin
          spi_miso = cur_bit; settle = 1'b0;
        end
      end
      csl_p = spi_csl; sclk_p = spi_sclk;
    end
  end

  task automatic run_frame(input int inj, output int len, output int t_ena);
    @(negedge clk) ena = 1'b1;
    @(negedge clk) ena = 1'b0;
    t_ena = neg_cnt;
    len = 0;
    while (busy === 1'b1 && len < 4 * FRAME_LEN) begin
      ena = (len == inj);
      len++;
      @(negedge clk);
    end
    ena = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ena = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (spi_csl !== 1'b1)  begin failures++; $display("FAIL reset_csl got=%b exp=1", spi_csl); end
    checks++; if (spi_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", spi_sclk); end
    checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", spi_mosi); end
    checks++; if (cyc_num !== 2'd0)  begin failures++; $display("FAIL reset_cyc got=%0d exp=0", cyc_num); end
    checks++; if (data !== 16'h0)    begin failures++; $display("FAIL reset_data got=%h exp=0000", data); end
    checks++; if (data_stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", data_stb); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ovr !== 1'b0)      begin failures++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_ena_busy got=%b exp=0", busy); end
    checks++; if (stb_cnt !== 0) begin failures++; $display("FAIL idle_no_ena_stb got=%0d exp=0", stb_cnt); end
  endtask

  task automatic test_basic_frame();
    int sb, hb, cb, ob, len, te;
    for (int i = 0; i < 4; i++) addr_tab[i] = 24'h000100;
    sb = stb_q.size(); hb = hdr_q.size(); cb = cs_len_q.size(); ob = ovr_cnt;
    run_frame(-1, len, te);
    repeat (5) @(negedge clk);
    checks++; if (len !== FRAME_LEN) begin failures++; $display("FAIL basic_len got=%0d exp=%0d", len, FRAME_LEN); end
    checks++; if (stb_q.size() - sb !== 2 * NCYC) begin failures++; $display("FAIL basic_stb_cnt got=%0d exp=%0d", stb_q.size() - sb, 2 * NCYC); end
    for (int i = 0; i < 2 * NCYC; i++) begin
      checks++;
      if (stb_q[sb + i] !== ((i % 2) ? 16'h5678 : 16'h1234)) begin
        failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, stb_q[sb + i], (i % 2) ? 16'h5678 : 16'h1234);
      end
    end
    for (int t = 0; t < NCYC; t++) begin
      checks++; if (hdr_q[hb + t] !== {EXP_CMD, 24'h000100}) begin failures++; $display("FAIL basic_mosi[%0d] got=%h exp=%h", t, hdr_q[hb + t], {EXP_CMD, 24'h000100}); end
      checks++; if (cs_len_q[cb + t] !== CS_LEN) begin failures++; $display("FAIL basic_cs_len[%0d] got=%0d exp=%0d", t, cs_len_q[cb + t], CS_LEN); end
      checks++; if (rise_q[cb + t] !== NSCLK) begin failures++; $display("FAIL basic_sclks[%0d] got=%0d exp=%0d", t, rise_q[cb + t], NSCLK); end
    end
    checks++; if (!(stb_t_q[sb] - te >= 2)) begin failures++; $display("FAIL first_stb_latency got=%0d exp>=2", stb_t_q[sb] - te); end
    checks++; if (cyc_num !== 2'd0) begin failures++; $display("FAIL basic_cyc_end got=%0d exp=0", cyc_num); end
    checks++; if (ovr_cnt !== ob) begin failures++; $display("FAIL basic_ovr got=%0d exp=%0d", ovr_cnt, ob); end
    checks++; if (mosi_err !== 0) begin failures++; $display("FAIL mosi_idle got=%0d exp=0", mosi_err); end
  endtask

  task automatic test_sclk_timing();
    checks++; if (run_min !== DIV) begin failures++; $display("FAIL sclk_phase_min got=%0d exp=%0d", run_min, DIV); end
    checks++; if (run_max !== DIV) begin failures++; $display("FAIL sclk_phase_max got=%0d exp=%0d", run_max, DIV); end
  endtask

  task automatic test_addr_mux();
    int hb, qb, sb, len, te;
    logic [23:0] ea [4];
    logic [15:0] ew [4];
    ea[0] = 24'h010000; ea[1] = 24'h020000; ea[2] = 24'h030000; ea[3] = 24'h010000;
    ew[0] = 16'hA5A4;   ew[1] = 16'hA6A7;   ew[2] = 16'hA7A6;   ew[3] = 16'hA5A4;
    for (int i = 0; i < 4; i++) addr_tab[i] = ea[i];
    hb = hdr_q.size(); qb = cyc_q.size(); sb = stb_q.size();
    run_frame(-1, len, te);
    repeat (5) @(negedge clk);
    for (int t = 0; t < NCYC; t++) begin
      checks++; if (hdr_q[hb + t] !== {EXP_CMD, ea[t]}) begin failures++; $display("FAIL mux_adr[%0d] got=%h exp=%h", t, hdr_q[hb + t], {EXP_CMD, ea[t]}); end
      checks++; if (cyc_q[qb + t] !== t) begin failures++; $display("FAIL mux_cyc[%0d] got=%0d exp=%0d", t, cyc_q[qb + t], t); end
      checks++; if (stb_q[sb + 2 * t] !== ew[t]) begin failures++; $display("FAIL mux_data[%0d] got=%h exp=%h", t, stb_q[sb + 2 * t], ew[t]); end
    end
    checks++; if (cyc_num !== 2'd0) begin failures++; $display("FAIL mux_cyc_end got=%0d exp=0", cyc_num); end
  endtask

  task automatic test_overrun();
    int ob, sb, tb0, len, te;
    for (int i = 0; i < 4; i++) addr_tab[i] = 24'h000100;
    ob = ovr_cnt; sb = stb_cnt;
    run_frame(300, len, te);
    repeat (5) @(negedge clk);
    checks++; if (ovr_cnt - ob !== 1) begin failures++; $display("FAIL ovr_mid_pulses got=%0d exp=1", ovr_cnt - ob); end
    checks++; if (len !== FRAME_LEN) begin failures++; $display("FAIL ovr_mid_len got=%0d exp=%0d", len, FRAME_LEN); end
    checks++; if (stb_cnt - sb !== 2 * NCYC) begin failures++; $display("FAIL ovr_mid_stb got=%0d exp=%0d", stb_cnt - sb, 2 * NCYC); end
    // ena lands on the very clk where the last GAP hands back to IDLE
    ob = ovr_cnt; sb = stb_cnt; tb0 = txn_cnt;
    run_frame(FRAME_LEN - 1, len, te);
    repeat (20) @(negedge clk);
    checks++; if (len !== FRAME_LEN) begin failures++; $display("FAIL ovr_end_len got=%0d exp=%0d", len, FRAME_LEN); end
    checks++; if (ovr_cnt - ob !== 1) begin failures++; $display("FAIL ovr_end_pulses got=%0d exp=1", ovr_cnt - ob); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_end_busy got=%b exp=0", busy); end
    checks++; if (txn_cnt - tb0 !== NCYC) begin failures++; $display("FAIL ovr_end_txns got=%0d exp=%0d", txn_cnt - tb0, NCYC); end
    checks++; if (stb_cnt - sb !== 2 * NCYC) begin failures++; $display("FAIL ovr_end_stb got=%0d exp=%0d", stb_cnt - sb, 2 * NCYC); end
  endtask

  task automatic test_reset_mid();
    int sb, sb2, qb, n, len, te;
    for (int i = 0; i < 4; i++) addr_tab[i] = 24'h000100;
    sb = stb_cnt;
    @(negedge clk) ena = 1'b1;
    @(negedge clk) ena = 1'b0;
    n = 0;
    while (stb_cnt < sb + 3 && n < 2 * FRAME_LEN) begin @(negedge clk); n++; end
    checks++; if (cyc_num !== 2'd1 || spi_csl !== 1'b0) begin failures++; $display("FAIL rmid_in_cycle1 got=cyc%0d csl%b exp=cyc1 csl0", cyc_num, spi_csl); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (spi_csl !== 1'b1)  begin failures++; $display("FAIL rmid_csl got=%b exp=1", spi_csl); end
    checks++; if (spi_sclk !== 1'b0) begin failures++; $display("FAIL rmid_sclk got=%b exp=0", spi_sclk); end
    checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL rmid_mosi got=%b exp=0", spi_mosi); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (cyc_num !== 2'd0)  begin failures++; $display("FAIL rmid_cyc got=%0d exp=0", cyc_num); end
    checks++; if (data !== 16'h0)    begin failures++; $display("FAIL rmid_data got=%h exp=0000", data); end
    checks++; if (data_stb !== 1'b0) begin failures++; $display("FAIL rmid_stb got=%b exp=0", data_stb); end
    checks++; if (ovr !== 1'b0)      begin failures++; $display("FAIL rmid_ovr got=%b exp=0", ovr); end
    @(negedge clk) reset = 1'b0;
    sb2 = stb_cnt;
    repeat (3 * CS_LEN) @(negedge clk);
    checks++; if (stb_cnt !== sb2) begin failures++; $display("FAIL rmid_no_stb got=%0d exp=%0d", stb_cnt - sb2, 0); end
    checks++; if (busy !== 1'b0 || spi_csl !== 1'b1) begin failures++; $display("FAIL rmid_idle got=busy%b csl%b exp=busy0 csl1", busy, spi_csl); end
    qb = stb_q.size();
    run_frame(-1, len, te);
    repeat (5) @(negedge clk);
    checks++; if (len !== FRAME_LEN) begin failures++; $display("FAIL rmid_refire_len got=%0d exp=%0d", len, FRAME_LEN); end
    checks++; if (stb_q.size() - qb !== 2 * NCYC) begin failures++; $display("FAIL rmid_refire_stb got=%0d exp=%0d", stb_q.size() - qb, 2 * NCYC); end
    checks++; if (stb_q[qb] !== 16'h1234) begin failures++; $display("FAIL rmid_refire_data got=%h exp=1234", stb_q[qb]); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) addr_tab[i] = 24'h000100;
    test_reset();
    test_basic_frame();
    test_sclk_timing();
    test_addr_mux();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wave_flash_rd.md
WAVE_FLASH_RD -- requirements
Module: wave_flash_rd

Interface
REQ-001 Parameter DIV, default 2, meaning half-period of spi_sclk in clk cycles (DIV>=1).
REQ-002 Parameter NCYC, default 4, meaning read transactions per sample frame.
REQ-003 Parameter GAP, default 4, meaning minimum clk cycles spi_csl is held high between transactions.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ena  input  1  sample-rate enable pulse; starts a frame.
REQ-007 cyc_num  output  2  current access cycle number, drives the requester's address mux.
REQ-008 addr  input  24  flash byte address for the current cyc_num, combinational from the requester.
REQ-009 data  output  16  signed read word, held until the next word.
REQ-010 data_stb  output  1  one-clk strobe, data valid.
REQ-011 busy  output  1  frame in progress.
REQ-012 ovr  output  1  one-clk pulse, ena arrived while busy.
REQ-013 spi_csl, spi_sclk, spi_mosi  output  1 each  SPI flash chip select (active low), clock, data out.
REQ-014 spi_miso  input  1  SPI flash data in.

Function
REQ-015 The SPI link SHALL be mode 0: spi_sclk idles low, mosi changes on the falling edge, miso is sampled on the rising edge, and each sclk phase lasts DIV clk cycles.
REQ-016 The state machine SHALL use the states IDLE, LATCH, CMD, ADR, DUMMY, DATA, GAP.
REQ-017 In IDLE with ena=1, the block SHALL set cyc_num=0 and busy=1 and go to LATCH.
REQ-018 LATCH SHALL sample addr one clk after cyc_num settles, assert spi_csl low, and go to CMD.
REQ-019 CMD SHALL shift out 8 command bits MSB first; ADR SHALL shift out the 24 latched address bits MSB first.
REQ-020 DATA SHALL shift in 32 bits as 4 bytes, which form 2 words; each word is little-endian, with the first byte received as the low byte.
REQ-021 On completion of each 16-bit word, data SHALL update and data_stb SHALL pulse exactly once, giving 2 strobes per transaction and 2*NCYC strobes per frame.
REQ-022 After the last data bit, spi_csl SHALL go high and spi_sclk low, and the block SHALL stay in GAP for GAP clks.
REQ-023 On leaving GAP, if cyc_num<NCYC-1 the block SHALL increment cyc_num and go to LATCH; otherwise it SHALL set cyc_num=0 and busy=0 and go to IDLE.
REQ-024 The first data_stb of a frame SHALL occur no earlier than 2 clks after ena, so that the requester's ena-cleared counter is valid.
REQ-025 An ena received while busy=1 SHALL NOT restart or alter the frame and SHALL pulse ovr.
REQ-026 An ena coincident with the final GAP-to-IDLE transition SHALL be treated as busy, so it is ignored and ovr pulses.
REQ-027 The address SHALL be used verbatim with no wrap adjustment; wrap at 0xFFFFFF is the flash device's behaviour.
REQ-028 spi_mosi SHALL be 0 outside CMD and ADR.

Reset
REQ-029 On reset, the block SHALL be in state IDLE with cyc_num=0, data=0, data_stb=0, busy=0, ovr=0, spi_csl=1, spi_sclk=0, spi_mosi=0.
REQ-030 Reset asserted mid-transaction SHALL raise spi_csl on the next clk, and no further data_stb SHALL be issued.
REQ-031 The first frame after reset release SHALL require a fresh ena.

Configuration
REQ-032 With macro WAVE_FLASH_RD_FAST_READ_EN defined, the command SHALL be 0x0B and the DUMMY state SHALL insert 8 sclk cycles with mosi=0 between ADR and DATA, for 72 sclk per transaction.
REQ-033 Without the macro, the command SHALL be 0x03 and DUMMY SHALL be skipped, for 64 sclk per transaction.

Verification
REQ-034 Reset, DIV=2, ena at t0, flash model with word 0x1234 stored at bytes 0x000100/0x000101 = 0x34/0x12, and addr=0x000100 for all cycles -> 8 strobes; the first data=0x1234; mosi carries 0x03, 0x00, 0x01, 0x00; busy falls after 4 transactions.
REQ-035 addr mux returning 0x010000, 0x020000, 0x030000, 0x010000 by cyc_num -> the ADR fields match in that order, and cyc_num steps 0,1,2,3,0.
REQ-036 Second ena pulsed mid-frame -> one ovr pulse, frame length unchanged, and 8 strobes total.
REQ-037 Reset asserted during DATA of cycle 1 -> spi_csl=1 within 1 clk, outputs at REQ-029 values, and no further strobes until the next ena.
REQ-038 WAVE_FLASH_RD_FAST_READ_EN defined -> command 0x0B, 8 dummy sclks, and each transaction spans 72*2*DIV clks of spi_csl low.
REQ-039 Measure spi_sclk -> high and low phases are each DIV clks, and miso is sampled only on rising edges.
